// File: rtl/median_window_11.sv
// median_window_11: sliding 11-sample window former feeding the median/sort network.
// Optional build macro MEDIAN_WINDOW_REPLICATE_EN: replicate the first sample of each frame across the window.
module median_window_11 #(
  parameter int DATA_WIDTH = 32,
  parameter int STRIDE     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_0,
  output logic [DATA_WIDTH-1:0] data_1,
  output logic [DATA_WIDTH-1:0] data_2,
  output logic [DATA_WIDTH-1:0] data_3,
  output logic [DATA_WIDTH-1:0] data_4,
  output logic [DATA_WIDTH-1:0] data_5,
  output logic [DATA_WIDTH-1:0] data_6,
  output logic [DATA_WIDTH-1:0] data_7,
  output logic [DATA_WIDTH-1:0] data_8,
  output logic [DATA_WIDTH-1:0] data_9,
  output logic [DATA_WIDTH-1:0] data_10,
  output logic [3:0]            fill_count
);

  localparam int         Depth      = 11;
  localparam logic [3:0] FullCount  = 4'd11;
  localparam logic [3:0] StrideLast = 4'(STRIDE - 1);

  logic [DATA_WIDTH-1:0] r_win [Depth];
  logic                  r_out_valid;
  logic [3:0]            r_fill;
  logic [3:0]            r_stride;

  logic                  w_accept;
  logic                  w_load_all;
  logic                  w_emit;
  logic [3:0]            w_fill_next;
  logic [3:0]            w_stride_next;

  // No skid buffer: a held window blocks new samples so the outputs stay stable.
  assign in_ready = !rst && !(r_out_valid && !out_ready);
  assign w_accept = in_valid && in_ready;

`ifdef MEDIAN_WINDOW_REPLICATE_EN
  assign w_load_all = w_accept && (r_fill == 4'd0);
`else
  assign w_load_all = 1'b0;
`endif

  always_comb begin
    w_emit        = 1'b0;
    w_fill_next   = r_fill;
    w_stride_next = r_stride;
    if (w_accept) begin
      if (w_load_all) begin
        w_emit        = 1'b1;
        w_fill_next   = FullCount;
        w_stride_next = 4'd0;
      end else if (r_fill == FullCount - 4'd1) begin
        w_emit        = 1'b1;
        w_fill_next   = FullCount;
        w_stride_next = 4'd0;
      end else if (r_fill == FullCount) begin
        if (r_stride == StrideLast) begin
          w_emit        = 1'b1;
          w_stride_next = 4'd0;
        end else begin
          w_stride_next = r_stride + 4'd1;
        end
      end else begin
        w_fill_next = r_fill + 4'd1;
      end
      // Frame end restarts the count; data registers keep their stale contents.
      if (in_last) begin
        w_fill_next   = 4'd0;
        w_stride_next = 4'd0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < Depth; k++) begin
        r_win[k] <= '0;
      end
      r_out_valid <= 1'b0;
      r_fill      <= 4'd0;
      r_stride    <= 4'd0;
    end else begin
      if (w_accept) begin
        if (w_load_all) begin
          for (int k = 0; k < Depth; k++) begin
            r_win[k] <= in_data;
          end
        end else begin
          for (int k = 0; k < Depth - 1; k++) begin
            r_win[k] <= r_win[k+1];
          end
          r_win[Depth-1] <= in_data;
        end
      end
      r_fill   <= w_fill_next;
      r_stride <= w_stride_next;
      if (w_emit) begin
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign fill_count = r_fill;
  assign data_0     = r_win[0];
  assign data_1     = r_win[1];
  assign data_2     = r_win[2];
  assign data_3     = r_win[3];
  assign data_4     = r_win[4];
  assign data_5     = r_win[5];
  assign data_6     = r_win[6];
  assign data_7     = r_win[7];
  assign data_8     = r_win[8];
  assign data_9     = r_win[9];
  assign data_10    = r_win[10];

endmodule
